// File: rtl/pc_target_lut_pkg.sv
// pc_lut_pkg: shared FSM state type and the default branch-target program table.
package pc_lut_pkg;
  typedef enum logic [1:0] {INIT = 2'b01, READY = 2'b10} state_t;
  localparam int DEF_DEPTH = 32;
  localparam logic [11:0] DEF_TGT [DEF_DEPTH] = '{
    12'd7, 12'd47, 12'd56, 12'd58, 12'd66, 12'd75, 12'd77, 12'd107,
    12'd114, 12'd121, 12'd128, 12'd148, 12'd47, 12'd50, 12'd62, 12'd66,
    12'd75, 12'd78, 12'd81, 12'd84, 12'd27, 12'd58, 12'd64, 12'd79,
    12'd110, 12'd121, 12'd124, 12'd130, 12'd134, 12'd1, 12'd1, 12'd1};
  localparam logic [DEF_DEPTH-1:0] DEF_REL = '0;
  function automatic logic [11:0] default_target(input int unsigned idx);
    return (idx < DEF_DEPTH) ? DEF_TGT[idx[4:0]] : 12'd0;
  endfunction
  function automatic logic default_rel(input int unsigned idx);
    return (idx < DEF_DEPTH) ? DEF_REL[idx[4:0]] : 1'b0;
  endfunction
endpackage

// File: rtl/pc_target_lut_if.sv
// pc_target_lut_if: lookup, write and status signals of the branch-target table.
interface pc_target_lut_if #(parameter int D = 12, parameter int A = 5);
  logic         lut_rd_en;
  logic [A-1:0] addr_lut;
  logic [D-1:0] pc_in;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;
  logic [D-1:0] target;
  logic         target_valid;
  logic         lut_miss;
  logic         init_busy;
  logic         wr_err;
  modport master (output lut_rd_en, addr_lut, pc_in, wr_en, wr_addr, wr_data, wr_rel,
                  input target, target_valid, lut_miss, init_busy, wr_err);
  modport slave (input lut_rd_en, addr_lut, pc_in, wr_en, wr_addr, wr_data, wr_rel,
                 output target, target_valid, lut_miss, init_busy, wr_err);
endinterface

// File: rtl/pc_target_lut_init_seq.sv
// pc_lut_init_seq: INIT/READY sequencer that walks the table index once after reset.
module pc_lut_init_seq
  import pc_lut_pkg::*;
#(
  parameter int A     = 5,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         Clk,
  input  logic         Reset,
  output logic         init_we,
  output logic [A-1:0] idx,
  output logic         busy
);
  state_t state;
  assign init_we = busy;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= INIT;
      idx   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          idx <= idx + 1'b1;
          if (idx == A'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: busy <= 1'b0;
        default: begin
          state <= INIT;
          idx   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
endmodule

// File: rtl/pc_target_lut.sv
// pc_target_lut: writable absolute/PC-relative branch-target table with registered lookup.
module pc_target_lut
  import pc_lut_pkg::*;
#(
  parameter int D     = 12,
  parameter int A     = 5,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic             Clk,
  input logic             Reset,
  pc_target_lut_if.slave  bus
);
  logic         busy, init_we, wr_hit, rd_hit, ram_we, rd_go;
  logic [A-1:0] idx, waddr;
  logic [D:0]   wdata, entry;
  logic [D-1:0] resolved;
  logic [D:0]   mem [DEPTH];
  pc_lut_init_seq #(.A(A), .DEPTH(DEPTH)) u_seq (
    .Clk(Clk), .Reset(Reset), .init_we(init_we), .idx(idx), .busy(busy));
  always_comb begin
    wr_hit   = 32'(bus.wr_addr) < DEPTH;
    rd_hit   = 32'(bus.addr_lut) < DEPTH;
    rd_go    = bus.lut_rd_en && !busy;
    ram_we   = init_we || (bus.wr_en && wr_hit);
    waddr    = init_we ? idx : bus.wr_addr;
    wdata    = init_we ? {default_rel(32'(idx)), D'(default_target(32'(idx)))}
                       : {bus.wr_rel, bus.wr_data};
    entry    = mem[bus.addr_lut];
    resolved = entry[D] ? bus.pc_in + entry[D-1:0] : entry[D-1:0];
  end
  // Storage has no reset; the sequencer rewrites every entry after reset.
  always_ff @(posedge Clk)
    if (ram_we) mem[waddr] <= wdata;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      bus.target       <= '0;
      bus.target_valid <= 1'b0;
      bus.lut_miss     <= 1'b0;
      bus.wr_err       <= 1'b0;
    end else begin
      bus.wr_err       <= bus.wr_en && (busy || !wr_hit);
      bus.target_valid <= rd_go;
      bus.lut_miss     <= rd_go && !rd_hit;
      if (rd_go) bus.target <= rd_hit ? resolved : '0;
    end
  assign bus.init_busy = busy;
endmodule

// File: tb/tb_pc_target_lut.sv
// tb_pc_target_lut: directed and randomized checks of two table builds (32 and 24 entries).
module tb_pc_target_lut;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32, rst24;
  pc_target_lut_if #(.D(12), .A(5)) b32();
  pc_target_lut_if #(.D(12), .A(5)) b24();
  pc_target_lut #(.D(12), .A(5), .DEPTH(32)) dut32 (.Clk(clk), .Reset(rst32), .bus(b32.slave));
  pc_target_lut #(.D(12), .A(5), .DEPTH(24)) dut24 (.Clk(clk), .Reset(rst24), .bus(b24.slave));
  int checks = 0, failures = 0;
  int defs [32] = '{7, 47, 56, 58, 66, 75, 77, 107, 114, 121, 128, 148, 47, 50, 62, 66,
                    75, 78, 81, 84, 27, 58, 64, 79, 110, 121, 124, 130, 134, 1, 1, 1};
  int m32v [32], m32r [32], m24v [32], m24r [32];
  int t32, t24;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int res(input int v, input int r, input int pc);
    return r != 0 ? (pc + v) % 4096 : v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    b32.lut_rd_en = 0; b32.addr_lut = 0; b32.pc_in = 0;
    b32.wr_en = 0; b32.wr_addr = 0; b32.wr_data = 0; b32.wr_rel = 0;
    b24.lut_rd_en = 0; b24.addr_lut = 0; b24.pc_in = 0;
    b24.wr_en = 0; b24.wr_addr = 0; b24.wr_data = 0; b24.wr_rel = 0;
  endtask
  task automatic rd32(input int a, input int pc, input int exp, input string tag);
    b32.lut_rd_en = 1; b32.addr_lut = 5'(a); b32.pc_in = 12'(pc);
    tick();
    b32.lut_rd_en = 0;
    chk(tag, b32.target, exp);
    chk({tag, "_valid"}, b32.target_valid, 1);
    chk({tag, "_miss"}, b32.lut_miss, 0);
  endtask
  task automatic wr32(input int a, input int d, input int rel);
    b32.wr_en = 1; b32.wr_addr = 5'(a); b32.wr_data = 12'(d); b32.wr_rel = rel[0];
    tick();
    b32.wr_en = 0;
    chk("wr32_err", b32.wr_err, 0);
  endtask
  initial begin
    int n32, n24, rd, ra, pc, we, wa, wd, wr, e32, e24;
    idle();
    rst32 = 1; rst24 = 1;
    repeat (2) tick();
    chk("rst_busy32", b32.init_busy, 1);
    chk("rst_target32", b32.target, 0);
    chk("rst_valid32", b32.target_valid, 0);
    chk("rst_miss32", b32.lut_miss, 0);
    chk("rst_err32", b32.wr_err, 0);
    chk("rst_busy24", b24.init_busy, 1);
    chk("rst_err24", b24.wr_err, 0);
    rst32 = 0; rst24 = 0;
    b32.lut_rd_en = 1; b32.addr_lut = 0;
    b32.wr_en = 1; b32.wr_addr = 4; b32.wr_data = 999;
    n32 = 0; n24 = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 1) begin
        chk("init_rd_valid", b32.target_valid, 0);
        chk("init_rd_hold", b32.target, 0);
        chk("init_wr_err", b32.wr_err, 1);
        idle();
      end
      if (i == 2) chk("init_wr_err_pulse", b32.wr_err, 0);
      if (n24 == 0 && !b24.init_busy) n24 = i;
      if (!b32.init_busy) begin
        n32 = i;
        break;
      end
    end
    chk("busy_len32", n32, 32);
    chk("busy_len24", n24, 24);
    for (int i = 0; i < 32; i++) begin
      m32v[i] = defs[i]; m32r[i] = 0; m24v[i] = defs[i]; m24r[i] = 0;
    end
    rd32(2, 0, 56, "read_def2");
    rd32(4, 0, 66, "init_write_dropped");
    wr32(5, 'hFFB, 1);
    rd32(5, 4, 'hFFF, "rel_neg");
    rd32(5, 0, 'hFFB, "rel_pc0");
    wr32(9, 20, 1);
    rd32(9, 'hFF0, 'h004, "rel_wrap");
    b32.wr_en = 1; b32.wr_addr = 3; b32.wr_data = 200; b32.wr_rel = 0;
    b32.lut_rd_en = 1; b32.addr_lut = 3;
    tick();
    idle();
    chk("read_first", b32.target, 58);
    rd32(3, 0, 200, "after_write");
    m32v[5] = 'hFFB; m32r[5] = 1; m32v[9] = 20; m32r[9] = 1; m32v[3] = 200;
    tick();
    chk("idle_valid", b32.target_valid, 0);
    chk("idle_miss", b32.lut_miss, 0);
    chk("idle_hold", b32.target, 200);
    t32 = 200;
    b24.lut_rd_en = 1; b24.addr_lut = 30;
    tick();
    idle();
    chk("miss_target", b24.target, 0);
    chk("miss_flag", b24.lut_miss, 1);
    chk("miss_valid", b24.target_valid, 1);
    b24.wr_en = 1; b24.wr_addr = 30; b24.wr_data = 5;
    tick();
    idle();
    chk("oob_wr_err", b24.wr_err, 1);
    b24.lut_rd_en = 1; b24.addr_lut = 23;
    tick();
    idle();
    chk("d24_last", b24.target, 79);
    chk("d24_last_miss", b24.lut_miss, 0);
    chk("oob_wr_err_pulse", b24.wr_err, 0);
    t24 = 79;
    for (int k = 0; k < 300; k++) begin
      rd = int'($urandom_range(0, 1)); ra = int'($urandom_range(0, 31));
      pc = int'($urandom_range(0, 4095)); we = int'($urandom_range(0, 1));
      wa = int'($urandom_range(0, 31)); wd = int'($urandom_range(0, 4095));
      wr = int'($urandom_range(0, 1));
      b32.lut_rd_en = rd[0]; b32.addr_lut = 5'(ra); b32.pc_in = 12'(pc);
      b32.wr_en = we[0]; b32.wr_addr = 5'(wa); b32.wr_data = 12'(wd); b32.wr_rel = wr[0];
      b24.lut_rd_en = rd[0]; b24.addr_lut = 5'(ra); b24.pc_in = 12'(pc);
      b24.wr_en = we[0]; b24.wr_addr = 5'(wa); b24.wr_data = 12'(wd); b24.wr_rel = wr[0];
      e32 = rd != 0 ? res(m32v[ra], m32r[ra], pc) : t32;
      e24 = rd != 0 ? (ra < 24 ? res(m24v[ra], m24r[ra], pc) : 0) : t24;
      if (we != 0) begin
        m32v[wa] = wd; m32r[wa] = wr;
        if (wa < 24) begin m24v[wa] = wd; m24r[wa] = wr; end
      end
      tick();
      idle();
      chk("rnd32_target", b32.target, e32);
      chk("rnd32_valid", b32.target_valid, rd);
      chk("rnd32_miss", b32.lut_miss, 0);
      chk("rnd32_err", b32.wr_err, 0);
      chk("rnd24_target", b24.target, e24);
      chk("rnd24_valid", b24.target_valid, rd);
      chk("rnd24_miss", b24.lut_miss, (rd != 0 && ra >= 24) ? 1 : 0);
      chk("rnd24_err", b24.wr_err, (we != 0 && wa >= 24) ? 1 : 0);
      t32 = e32; t24 = e24;
    end
    rst24 = 1;
    tick();
    rst24 = 0;
    repeat (10) tick();
    chk("mid_init_busy", b24.init_busy, 1);
    rst24 = 1;
    tick();
    chk("rerst_busy", b24.init_busy, 1);
    chk("rerst_target", b24.target, 0);
    rst24 = 0;
    n24 = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (!b24.init_busy) begin
        n24 = i;
        break;
      end
    end
    chk("rerst_busy_len", n24, 24);
    for (int a = 0; a < 24; a++) begin
      b24.lut_rd_en = 1; b24.addr_lut = 5'(a); b24.pc_in = 12'($urandom_range(0, 4095));
      tick();
      idle();
      chk("reload_target", b24.target, defs[a]);
      chk("reload_valid", b24.target_valid, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_target_lut.md
Name: pc_target_lut

Overview:
- Writable, parametrised branch-target table for the fetch stage; successor to the fixed combinational target LUT.
- Entries hold either an absolute target or a signed PC-relative offset. A per-entry mode bit selects which.
- After reset an init sequencer loads the default program table, one entry per cycle.
- Software/test harness may overwrite entries at runtime. Lookups are registered with one-cycle latency.

Parameters:
- D, 12, target/PC width in bits; all arithmetic is mod 2**D.
- A, 5, lookup address width.
- DEPTH, 32, number of implemented entries (1..2**A).

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- lut_rd_en  in  1  lookup request.
- addr_lut  in  A  lookup index.
- pc_in  in  D  current PC, used by relative entries.
- wr_en  in  1  entry write strobe.
- wr_addr  in  A  write index.
- wr_data  in  D  absolute target or two's-complement offset.
- wr_rel  in  1  1 = relative entry, 0 = absolute.
- target  out  D  resolved branch target.
- target_valid  out  1  target holds a fresh lookup result.
- lut_miss  out  1  last lookup addressed an index >= DEPTH.
- init_busy  out  1  init sequencer running.
- wr_err  out  1  one-cycle pulse: write rejected.

Behaviour:
- Reset (async assert): FSM goes to INIT, init index = 0. Outputs: target = 0, target_valid = 0, lut_miss = 0, init_busy = 1, wr_err = 0. Table contents are don't-care until rewritten.
- INIT state:
  - Each cycle writes entry[idx] = pkg default value and mode, then idx++.
  - After the cycle writing idx = DEPTH-1, go to READY. init_busy falls in the same edge, so it is low DEPTH cycles after Reset deasserts.
  - Reads in INIT: target_valid = 0 next cycle, target holds its value.
  - Writes in INIT: dropped, wr_err = 1 next cycle.
- READY state:
  - Write: on wr_en, entry[wr_addr] <= {wr_rel, wr_data} at the edge.
  - Write with wr_addr >= DEPTH: dropped, wr_err pulse.
  - Lookup: on lut_rd_en with addr_lut < DEPTH, next cycle target_valid = 1, lut_miss = 0.
    - Absolute entry: target = entry value.
    - Relative entry: target = (pc_in + entry) mod 2**D. Entry is treated as signed D-bit; pc_in is sampled in the request cycle. No overflow flag; wrap is silent.
  - Lookup with addr_lut >= DEPTH: next cycle target = 0, target_valid = 1, lut_miss = 1.
  - No lut_rd_en: target_valid = 0, lut_miss = 0, target holds its last value.
- Same-cycle read and write to the same index: read-first, so the lookup returns the old entry. The new value is visible from the next request.
- Back-to-back lookups: one result per cycle, fully pipelined, no stall.
- Reset asserted mid-INIT or mid-READY: immediate return to INIT with index 0; full reload. Runtime writes are lost.
- No FSM state other than INIT and READY is reachable. Illegal encodings go to INIT.

Decomposition:
- Shared package pc_lut_pkg:
  - state enum {INIT, READY}.
  - default depth constant 32.
  - function default_target(idx) returning the current program targets: 7, 47, 56, 58, 66, 75, 77, 107, 114, 121, 128, 148, 47, 50, 62, 66, 75, 78, 81, 84, 27, 58, 64, 79, 110, 121, 124, 130, 134, 1, 1, 1.
  - function default_rel(idx), all 0.
- Sub-module pc_lut_init_seq: INIT/READY FSM plus index counter. Emits init write enable, index and busy. The table storage, write arbitration and resolve adder stay in the top.

Test Plan:
- Reset, release, count cycles with no activity -> init_busy low exactly 32 cycles after release. Read addr 2 -> next cycle target = 56, target_valid = 1.
- lut_rd_en at addr 0 and wr_en at addr 4 during INIT -> target_valid = 0, wr_err pulses once. After INIT, addr 4 reads 66.
- Write addr 5 = 12'hFFB, wr_rel = 1; then read addr 5 with pc_in = 4 -> target = 12'hFFF. Same entry with pc_in = 12'h000 -> 12'hFFB.
- Write addr 9 = 20 relative; read with pc_in = 12'hFF0 -> target = 12'h004, showing the wrap.
- Same cycle: wr_en addr 3 = 200 absolute and lut_rd_en addr 3 -> target = 58. Next read of addr 3 -> 200.
- Build with DEPTH = 24: read addr 30 -> target = 0, lut_miss = 1. Write addr 30 -> wr_err. Then assert Reset mid-INIT at idx 10 -> init_busy stays high 24 further cycles and the table equals the package defaults.
